// File: rtl/as6d_pcs_rx_pldb_deframer_if.sv
// FIFO pop port and outgoing payload stream of the PCS RX payload-buffer deframer.
// The master side is the deframer; the slave side is the FIFO plus the downstream consumer.
interface as6d_pcs_rx_pldb_deframer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 72
);
  logic [WORD_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_data_val;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] pld_data;
  logic                  pld_sop;
  logic                  pld_eop;
  logic [7:0]            pld_keep;
  logic                  pld_err;
  logic                  pld_valid;
  logic                  pld_ready;

  modport master (
    input  fifo_rd_data, fifo_rd_data_val,
    output fifo_rd_en,
    output pld_data, pld_sop, pld_eop, pld_keep, pld_err, pld_valid,
    input  pld_ready
  );

  modport slave (
    output fifo_rd_data, fifo_rd_data_val,
    input  fifo_rd_en,
    input  pld_data, pld_sop, pld_eop, pld_keep, pld_err, pld_valid,
    output pld_ready
  );
endinterface

// File: rtl/as6d_pcs_rx_pldb_deframer.sv
// Pops FWFT payload words, enforces sop/eop framing, and emits a sop/eop/keep/err stream
// through a 2-entry skid buffer while keeping saturating good/errored packet counts.
module as6d_pcs_rx_pldb_deframer #(
  parameter int DATA_WIDTH = 64,
  parameter int WORD_WIDTH = 72,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  as6d_pcs_rx_pldb_deframer_if.master    bus,
  input  logic                           cnt_clr,
  output logic [CNT_WIDTH-1:0]           pkt_cnt,
  output logic [CNT_WIDTH-1:0]           err_pkt_cnt,
  output logic                           sop_err_int,
  output logic                           orphan_int
);

  localparam int KEEP_WIDTH = 8;
  localparam int SOP_BIT    = WORD_WIDTH - 1;
  localparam int EOP_BIT    = WORD_WIDTH - 2;
  localparam int NB_HI      = WORD_WIDTH - 3;
  localparam int NB_LO      = WORD_WIDTH - 5;
  localparam int ERR_BIT    = WORD_WIDTH - 6;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  err;
  } beat_t;

  function automatic logic [KEEP_WIDTH-1:0] keep_of(input logic eop, input logic [2:0] nb);
    logic [KEEP_WIDTH-1:0] k;
    if (eop) begin
      k = 8'hFF >> (3'd7 - nb);
    end else begin
      k = 8'hFF;
    end
    return k;
  endfunction

  state_t                state_r;
  beat_t                 ent_r [2];
  logic [1:0]            occ_r;
  logic                  err_acc_r;
  logic [CNT_WIDTH-1:0]  pkt_cnt_r;
  logic [CNT_WIDTH-1:0]  err_pkt_cnt_r;
  logic                  sop_err_int_r;
  logic                  orphan_int_r;

  logic                  h_sop_s;
  logic                  h_eop_s;
  logic [2:0]            h_nb_s;
  logic                  h_err_s;
  logic [DATA_WIDTH-1:0] h_data_s;
  logic                  unused_rsvd_s;
  logic                  slot_s;
  logic                  fire_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  synth_s;
  logic                  orphan_s;
  logic                  sop_err_s;
  state_t                state_n_s;
  beat_t                 push_beat_s;
  beat_t                 ent_n_s [2];
  logic [1:0]            occ_n_s;

  assign h_sop_s       = bus.fifo_rd_data[SOP_BIT];
  assign h_eop_s       = bus.fifo_rd_data[EOP_BIT];
  assign h_nb_s        = bus.fifo_rd_data[NB_HI:NB_LO];
  assign h_err_s       = bus.fifo_rd_data[ERR_BIT];
  assign h_data_s      = bus.fifo_rd_data[DATA_WIDTH-1:0];
  assign unused_rsvd_s = ^bus.fifo_rd_data[DATA_WIDTH+1:DATA_WIDTH];

  assign bus.pld_valid = (occ_r != 2'd0);
  assign bus.pld_data  = ent_r[0].data;
  assign bus.pld_sop   = ent_r[0].sop;
  assign bus.pld_eop   = ent_r[0].eop;
  assign bus.pld_keep  = ent_r[0].keep;
  assign bus.pld_err   = ent_r[0].err;
  assign bus.fifo_rd_en = pop_s;

  assign pkt_cnt     = pkt_cnt_r;
  assign err_pkt_cnt = err_pkt_cnt_r;
  assign sop_err_int = sop_err_int_r;
  assign orphan_int  = orphan_int_r;

  // Framing decision for the FIFO head word; a SOP inside a packet is answered with a terminator beat.
  always_comb begin
    slot_s      = (occ_r == 2'd0) || ((occ_r == 2'd1) && bus.pld_ready);
    pop_s       = 1'b0;
    push_s      = 1'b0;
    synth_s     = 1'b0;
    orphan_s    = 1'b0;
    sop_err_s   = 1'b0;
    state_n_s   = state_r;
    if (bus.fifo_rd_data_val && slot_s) begin
      case (state_r)
        ST_IDLE: begin
          if (h_sop_s) begin
            pop_s     = 1'b1;
            push_s    = 1'b1;
            state_n_s = h_eop_s ? ST_IDLE : ST_IN_PKT;
          end else begin
            pop_s    = 1'b1;
            orphan_s = 1'b1;
          end
        end
        ST_IN_PKT: begin
          if (!h_sop_s) begin
            pop_s     = 1'b1;
            push_s    = 1'b1;
            state_n_s = h_eop_s ? ST_IDLE : ST_IN_PKT;
          end else begin
            push_s    = 1'b1;
            synth_s   = 1'b1;
            sop_err_s = 1'b1;
            state_n_s = ST_IDLE;
          end
        end
        default: begin
          state_n_s = ST_IDLE;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end

    if (synth_s) begin
      push_beat_s.data = {DATA_WIDTH{1'b0}};
      push_beat_s.sop  = 1'b0;
      push_beat_s.eop  = 1'b1;
      push_beat_s.keep = {KEEP_WIDTH{1'b0}};
      push_beat_s.err  = 1'b1;
    end else begin
      push_beat_s.data = h_data_s;
      push_beat_s.sop  = h_sop_s;
      push_beat_s.eop  = h_eop_s;
      push_beat_s.keep = keep_of(h_eop_s, h_nb_s);
      push_beat_s.err  = h_eop_s ? (h_err_s | err_acc_r) : h_err_s;
    end
  end

  // Skid buffer next state: retire the head on handshake, then append the new beat behind what is left.
  always_comb begin
    fire_s     = bus.pld_valid & bus.pld_ready;
    ent_n_s[0] = ent_r[0];
    ent_n_s[1] = ent_r[1];
    occ_n_s    = occ_r;
    if (fire_s) begin
      ent_n_s[0] = ent_r[1];
      ent_n_s[1] = '0;
      occ_n_s    = occ_r - 2'd1;
    end else begin
      occ_n_s    = occ_r;
    end
    if (push_s) begin
      ent_n_s[occ_n_s[0]] = push_beat_s;
      occ_n_s             = occ_n_s + 2'd1;
    end else begin
      occ_n_s             = occ_n_s;
    end
  end

  // Framing FSM, skid buffer storage, sticky packet error and interrupt pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ent_r[0]      <= '0;
      ent_r[1]      <= '0;
      occ_r         <= 2'd0;
      err_acc_r     <= 1'b0;
      sop_err_int_r <= 1'b0;
      orphan_int_r  <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      ent_r[0]      <= ent_n_s[0];
      ent_r[1]      <= ent_n_s[1];
      occ_r         <= occ_n_s;
      sop_err_int_r <= sop_err_s;
      orphan_int_r  <= orphan_s;
      if (push_s) begin
        err_acc_r <= push_beat_s.eop ? 1'b0 : (err_acc_r | push_beat_s.err);
      end else begin
        err_acc_r <= err_acc_r;
      end
    end
  end

  // Saturating packet statistics, counted when the eop beat leaves; clear wins over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_r     <= {CNT_WIDTH{1'b0}};
      err_pkt_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (cnt_clr) begin
      pkt_cnt_r     <= {CNT_WIDTH{1'b0}};
      err_pkt_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (fire_s && ent_r[0].eop) begin
      if (ent_r[0].err) begin
        if (err_pkt_cnt_r != {CNT_WIDTH{1'b1}}) begin
          err_pkt_cnt_r <= err_pkt_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          err_pkt_cnt_r <= err_pkt_cnt_r;
        end
      end else begin
        if (pkt_cnt_r != {CNT_WIDTH{1'b1}}) begin
          pkt_cnt_r <= pkt_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
          pkt_cnt_r <= pkt_cnt_r;
        end
      end
    end else begin
      pkt_cnt_r     <= pkt_cnt_r;
      err_pkt_cnt_r <= err_pkt_cnt_r;
    end
  end

endmodule

// File: tb/tb_as6d_pcs_rx_pldb_deframer.sv
// Directed bench for the payload-buffer deframer: FWFT FIFO model in front, beat capture behind.
module tb_as6d_pcs_rx_pldb_deframer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [15:0] pkt_cnt;
  logic [15:0] err_pkt_cnt;
  logic        sop_err_int;
  logic        orphan_int;

  as6d_pcs_rx_pldb_deframer_if #(.DATA_WIDTH(64), .WORD_WIDTH(72)) bus ();

  as6d_pcs_rx_pldb_deframer #(.DATA_WIDTH(64), .WORD_WIDTH(72), .CNT_WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .cnt_clr     (cnt_clr),
    .pkt_cnt     (pkt_cnt),
    .err_pkt_cnt (err_pkt_cnt),
    .sop_err_int (sop_err_int),
    .orphan_int  (orphan_int)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [7:0]  keep;
    logic        err;
  } beat_t;

  logic [71:0] fq [$];
  beat_t       got_q [$];
  beat_t       exp_q [$];
  int          got_cyc [$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          bp_viol = 0;
  int          orphan_seen = 0;
  int          soperr_seen = 0;
  logic        s_rd_en;
  logic        s_valid;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mkw(input logic sop, input logic eop, input logic [2:0] nb,
                                      input logic err, input logic [63:0] d);
    return {sop, eop, nb, err, 2'b00, d};
  endfunction

  function automatic beat_t mkb(input logic [63:0] d, input logic sop, input logic eop,
                                input logic [7:0] keep, input logic err);
    return {d, sop, eop, keep, err};
  endfunction

  // One clock: present FIFO head, sample just before the edge, pop after it.
  task automatic step(input logic rdy);
    beat_t b;
    bus.pld_ready        = rdy;
    bus.fifo_rd_data_val = (fq.size() > 0);
    bus.fifo_rd_data     = (fq.size() > 0) ? fq[0] : 72'h0;
    #4;
    s_rd_en = bus.fifo_rd_en;
    s_valid = bus.pld_valid;
    if (bus.pld_valid && !rdy && s_rd_en) bp_viol++;
    if (bus.pld_valid && rdy) begin
      b = {bus.pld_data, bus.pld_sop, bus.pld_eop, bus.pld_keep, bus.pld_err};
      got_q.push_back(b);
      got_cyc.push_back(cyc);
    end
    if (orphan_int) orphan_seen++;
    if (sop_err_int) soperr_seen++;
    @(posedge clk);
    if (s_rd_en) void'(fq.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check_eq({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
  endtask

  initial begin
    bus.fifo_rd_data     = 72'h0;
    bus.fifo_rd_data_val = 1'b0;
    bus.pld_ready        = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 128'(bus.pld_valid), 128'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_outs", 128'({bus.pld_valid, bus.pld_sop, bus.pld_eop, bus.pld_keep, bus.pld_err,
                               sop_err_int, orphan_int}), 128'(0));
    check_eq("rst_cnts", 128'({pkt_cnt, err_pkt_cnt}), 128'(0));

    // Single-beat packet
    fq.push_back(mkw(1'b1, 1'b1, 3'd3, 1'b0, 64'h0123456789ABCDEF));
    step(1'b1);
    check_eq("t1_rd_en", 128'(s_rd_en), 128'(1'b1));
    check_eq("t1_lat0", 128'(s_valid), 128'(1'b0));
    step(1'b1);
    check_eq("t1_lat1", 128'(s_valid), 128'(1'b1));
    exp_q.push_back(mkb(64'h0123456789ABCDEF, 1'b1, 1'b1, 8'h0F, 1'b0));
    compare_beats("t1");
    check_eq("t1_pkt_cnt", 128'(pkt_cnt), 128'(16'd1));

    // 4-beat packet, err on beat 2
    fq.push_back(mkw(1'b1, 1'b0, 3'd0, 1'b0, 64'h1111111111111111));
    fq.push_back(mkw(1'b0, 1'b0, 3'd0, 1'b1, 64'h2222222222222222));
    fq.push_back(mkw(1'b0, 1'b0, 3'd0, 1'b0, 64'h3333333333333333));
    fq.push_back(mkw(1'b0, 1'b1, 3'd7, 1'b0, 64'h4444444444444444));
    repeat (6) step(1'b1);
    check_eq("t2_consec", 128'((got_cyc.size() == 4) ? (got_cyc[3] - got_cyc[0]) : -1), 128'(3));
    exp_q.push_back(mkb(64'h1111111111111111, 1'b1, 1'b0, 8'hFF, 1'b0));
    exp_q.push_back(mkb(64'h2222222222222222, 1'b0, 1'b0, 8'hFF, 1'b1));
    exp_q.push_back(mkb(64'h3333333333333333, 1'b0, 1'b0, 8'hFF, 1'b0));
    exp_q.push_back(mkb(64'h4444444444444444, 1'b0, 1'b1, 8'hFF, 1'b1));
    compare_beats("t2");
    check_eq("t2_cnts", 128'({pkt_cnt, err_pkt_cnt}), 128'({16'd1, 16'd1}));

    // 6-beat packet under toggling backpressure
    for (int i = 0; i < 6; i++) begin
      fq.push_back(mkw(i == 0, i == 5, 3'd5, 1'b0, 64'hA0A0A0A000000000 + 64'(i)));
    end
    for (int k = 0; k < 30; k++) step((k % 4 == 0) || (k % 4 == 3));
    check_eq("t3_bp_viol", 128'(bp_viol), 128'(0));
    check_eq("t3_fifo_empty", 128'(fq.size()), 128'(0));
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mkb(64'hA0A0A0A000000000 + 64'(i), i == 0, i == 5,
                          (i == 5) ? 8'h3F : 8'hFF, 1'b0));
    end
    compare_beats("t3");
    check_eq("t3_cnts", 128'({pkt_cnt, err_pkt_cnt}), 128'({16'd2, 16'd1}));

    // SOP inside a packet
    soperr_seen = 0;
    fq.push_back(mkw(1'b1, 1'b0, 3'd0, 1'b0, 64'hAAAAAAAAAAAAAAAA));
    fq.push_back(mkw(1'b0, 1'b0, 3'd0, 1'b0, 64'hBBBBBBBBBBBBBBBB));
    fq.push_back(mkw(1'b1, 1'b1, 3'd7, 1'b0, 64'hCCCCCCCCCCCCCCCC));
    repeat (8) step(1'b1);
    exp_q.push_back(mkb(64'hAAAAAAAAAAAAAAAA, 1'b1, 1'b0, 8'hFF, 1'b0));
    exp_q.push_back(mkb(64'hBBBBBBBBBBBBBBBB, 1'b0, 1'b0, 8'hFF, 1'b0));
    exp_q.push_back(mkb(64'h0, 1'b0, 1'b1, 8'h00, 1'b1));
    exp_q.push_back(mkb(64'hCCCCCCCCCCCCCCCC, 1'b1, 1'b1, 8'hFF, 1'b0));
    compare_beats("t4");
    check_eq("t4_soperr_pulses", 128'(soperr_seen), 128'(1));
    check_eq("t4_cnts", 128'({pkt_cnt, err_pkt_cnt}), 128'({16'd3, 16'd2}));

    // Orphan word in IDLE
    orphan_seen = 0;
    fq.push_back(mkw(1'b0, 1'b0, 3'd0, 1'b0, 64'hDEADBEEFDEADBEEF));
    step(1'b1);
    check_eq("t5_rd_en", 128'(s_rd_en), 128'(1'b1));
    repeat (3) step(1'b1);
    check_eq("t5_orphan_pulses", 128'(orphan_seen), 128'(1));
    check_eq("t5_no_beats", 128'(got_q.size()), 128'(0));
    check_eq("t5_fifo_empty", 128'(fq.size()), 128'(0));

    // Clear, saturate, then clear against a same-cycle increment
    cnt_clr = 1'b1;
    step(1'b1);
    cnt_clr = 1'b0;
    check_eq("t6_clr", 128'({pkt_cnt, err_pkt_cnt}), 128'(0));
    for (int i = 0; i < 65534; i++) begin
      fq.push_back(mkw(1'b1, 1'b1, 3'd7, 1'b0, 64'(i)));
      step(1'b1);
    end
    step(1'b1);
    check_eq("t6_fffe", 128'(pkt_cnt), 128'(16'hFFFE));
    for (int i = 0; i < 3; i++) begin
      fq.push_back(mkw(1'b1, 1'b1, 3'd0, 1'b0, 64'h5A5A));
      step(1'b1);
    end
    repeat (2) step(1'b1);
    check_eq("t6_sat", 128'(pkt_cnt), 128'(16'hFFFF));
    got_q.delete();
    got_cyc.delete();
    fq.push_back(mkw(1'b1, 1'b1, 3'd0, 1'b0, 64'h77));
    step(1'b1);
    cnt_clr = 1'b1;
    step(1'b1);
    cnt_clr = 1'b0;
    check_eq("t6_clr_eop_beat", 128'(s_valid), 128'(1'b1));
    check_eq("t6_clr_prio", 128'(pkt_cnt), 128'(16'd0));
    step(1'b1);
    check_eq("t6_clr_hold", 128'({pkt_cnt, err_pkt_cnt}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
